// File: rtl/mm2s_pkg.sv
// Shared types and constants for the mm2s burst read engine.
// Holds the AR FSM states, AXI encodings and beat-geometry helpers.
package mm2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ADDR,
    DRAIN
  } ar_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned BOUNDARY_4K = 4096;

  function automatic int unsigned beat_bytes(int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned beat_shift(int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/mm2s_data_fifo.sv
// Synchronous data FIFO for the read-data path.
// Ports: clk/rst, wr_en/wr_data in, rd_en/rd_data out, full/empty flags.
// Storage is registered: a written entry is visible the cycle after.
module mm2s_data_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Zero when empty so the stream side idles at all-zero payload.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mm2s_burst_engine.sv
// Memory-to-stream DMA read engine: splits byte commands into 4KB-safe
// INCR bursts, buffers R data with credit admission, emits AXI-Stream.
// Ports: cmd_* command in, sts_* completion, m_axi_ar*/r* read master,
// m_axis_* stream master.
module mm2s_burst_engine
  import mm2s_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  sts_done,
  output logic                  sts_err,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int BYTES = beat_bytes(DATA_W);
  localparam int SHIFT = beat_shift(DATA_W);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = DATA_W + BYTES + 1;

  ar_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    left_q, left_d;
  logic [LEN_W-1:0]    rx_left_q, rx_left_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [CW-1:0]       credits_q, credits_d;
  logic [BYTES-1:0]    keep_last_q, keep_last_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic                cmd_hs, ar_hs, r_hs, axis_hs;
  logic                credit_ok, ar_valid;
  logic [8:0]          burst_cnt, burst_calc;
  logic [12:0]         bytes_to_bound, beats_to_bound;
  logic [LEN_W:0]      len_ext;
  logic [LEN_W-1:0]    total_beats;
  logic [BYTES-1:0]    keep_rem;
  logic                r_last;
  logic [FW-1:0]       wr_data, rd_data;
  logic                fifo_full, fifo_empty;
  logic                unused_ok;

  assign unused_ok = m_axi_rlast ^ fifo_full;

  assign burst_cnt = {1'b0, arlen_q} + 9'd1;
  assign credit_ok = (credits_q >= CW'(burst_cnt));
  assign ar_valid  = (state_q == ADDR) && credit_ok;

  assign cmd_hs  = cmd_valid && cmd_ready;
  assign ar_hs   = ar_valid && m_axi_arready;
  assign r_hs    = m_axi_rvalid && m_axi_rready;
  assign axis_hs = m_axis_tvalid && m_axis_tready;

  assign len_ext     = {1'b0, cmd_len} + (LEN_W+1)'(BYTES - 1);
  assign total_beats = LEN_W'(len_ext >> SHIFT);
  assign keep_rem    = ~({BYTES{1'b1}} << cmd_len[SHIFT-1:0]);

  assign bytes_to_bound = 13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]};
  assign beats_to_bound = bytes_to_bound >> SHIFT;

  // Smallest of the burst cap, remaining beats and beats to the 4KB edge.
  always_comb begin
    burst_calc = 9'(MAX_BURST);
    if ({16'd0, left_q} < 32'(burst_calc))
      burst_calc = 9'(left_q);
    if (beats_to_bound < 13'(burst_calc))
      burst_calc = 9'(beats_to_bound);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    left_d      = left_q;
    arlen_d     = arlen_q;
    rx_left_d   = rx_left_q;
    keep_last_d = keep_last_q;
    err_d       = err_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d      = cmd_addr;
          left_d      = total_beats;
          rx_left_d   = total_beats;
          keep_last_d = (cmd_len[SHIFT-1:0] == '0) ? '1 : keep_rem;
          err_d       = 1'b0;
          state_d     = CALC;
        end
      end
      CALC: begin
        arlen_d = 8'(burst_calc - 9'd1);
        state_d = ADDR;
      end
      ADDR: begin
        if (ar_hs) begin
          addr_d  = addr_q + (ADDR_W'(burst_cnt) << SHIFT);
          left_d  = left_q - LEN_W'(burst_cnt);
          state_d = (left_q == LEN_W'(burst_cnt)) ? DRAIN : CALC;
        end
      end
      DRAIN: begin
        if (axis_hs && m_axis_tlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (r_hs && rx_left_q != '0)
      rx_left_d = rx_left_q - LEN_W'(1);
    if (r_hs && m_axi_rresp != RESP_OKAY)
      err_d = 1'b1;
  end

  // Credits mirror free FIFO slots including bursts still in flight.
  always_comb begin
    credits_d = credits_q;
    if (ar_hs)   credits_d = credits_d - CW'(burst_cnt);
    if (axis_hs) credits_d = credits_d + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      left_q      <= '0;
      rx_left_q   <= '0;
      arlen_q     <= '0;
      credits_q   <= CW'(FIFO_DEPTH);
      keep_last_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      rx_left_q   <= rx_left_d;
      arlen_q     <= arlen_d;
      credits_q   <= credits_d;
      keep_last_q <= keep_last_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign r_last  = (rx_left_q == LEN_W'(1));
  assign wr_data = {m_axi_rdata, (r_last ? keep_last_q : {BYTES{1'b1}}), r_last};

  mm2s_data_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (r_hs),
    .wr_data (wr_data),
    .rd_en   (m_axis_tready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready     = (state_q == IDLE) && !rst;
  assign m_axi_rready  = !rst;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SHIFT);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = ar_valid;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = rd_data[FW-1 -: DATA_W];
  assign m_axis_tkeep  = rd_data[BYTES:1];
  assign m_axis_tlast  = rd_data[0];

  assign sts_done = done_q;
  assign sts_err  = done_q && err_q;

endmodule

// File: tb/tb_mm2s_burst_engine.sv
// Randomized scoreboard bench for mm2s_burst_engine (DATA_W=64).
// Reference model plans bursts/beats with plain arithmetic.
module tb_mm2s_burst_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        sts_done, sts_err;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;

  always #5 clk = ~clk;

  mm2s_burst_engine dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .sts_done      (sts_done),
    .sts_err       (sts_err),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } bt_t;

  ar_t  exp_ar[$];
  bt_t  exp_bt[$];
  logic exp_st[$];
  ar_t  slv_q[$];
  bit   err_map[int unsigned];

  int passed = 0;
  int total  = 0;
  int ar_cnt = 0;
  int tmode  = 2;

  function automatic logic [63:0] memf(logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, ~a};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic plan_cmd(logic [31:0] a, int len, int err_beat);
    int beats, left, b, tob;
    logic [31:0] ad;
    bt_t t;
    beats = (len + 7) / 8;
    left  = beats;
    ad    = a;
    err_map.delete();
    while (left > 0) begin
      b   = 16;
      tob = (4096 - int'(ad % 4096)) / 8;
      if (left < b) b = left;
      if (tob < b) b = tob;
      exp_ar.push_back('{ad, 8'(b - 1)});
      ad   = ad + 32'(b * 8);
      left = left - b;
    end
    for (int i = 0; i < beats; i++) begin
      t.data = memf(a + 32'(i * 8));
      t.last = (i == beats - 1);
      t.keep = 8'hFF;
      if (t.last && (len % 8) != 0) t.keep = 8'((1 << (len % 8)) - 1);
      exp_bt.push_back(t);
    end
    if (err_beat >= 0) err_map[a + 32'(err_beat * 8)] = 1'b1;
    exp_st.push_back(err_beat >= 0);
  endtask

  task automatic issue(logic [31:0] a, int len, int err_beat);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      total++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end else begin
      plan_cmd(a, len, err_beat);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = 16'(len);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (exp_st.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_st.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_st.size());
    end
  endtask

  // AXI read slave: random AR acceptance and R gaps, data from memf.
  initial begin : slave
    bit rs, ar_hs, r_hs;
    int rb;
    ar_t cap;
    ar_t e;
    logic [31:0] ba;
    rb = 0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      rs    = rst;
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      cap   = '{m_axi_araddr, m_axi_arlen};
      if (!rs && ar_hs) begin
        ar_cnt++;
        if (exp_ar.size() == 0) begin
          total++;
          $display("FAIL ar_unexpected: got addr %0h expected none", m_axi_araddr);
        end else begin
          e = exp_ar.pop_front();
          chk("ar_addr", m_axi_araddr, e.addr);
          chk("ar_len", m_axi_arlen, e.len);
          chk("ar_size_burst", {m_axi_arsize, m_axi_arburst}, {3'd3, 2'b01});
        end
      end
      @(posedge clk); #1;
      if (rs) begin
        slv_q.delete();
        rb = 0;
        m_axi_rvalid  = 1'b0;
        m_axi_arready = 1'b0;
      end else begin
        if (r_hs && slv_q.size() != 0) begin
          rb++;
          if (rb > int'(slv_q[0].len)) begin
            void'(slv_q.pop_front());
            rb = 0;
          end
        end
        if (ar_hs) slv_q.push_back(cap);
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        if (slv_q.size() != 0 && $urandom_range(3) != 0) begin
          ba = slv_q[0].addr + 32'(rb * 8);
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = memf(ba);
          m_axi_rresp  = err_map.exists(ba) ? 2'b10 : 2'b00;
          m_axi_rlast  = (rb == int'(slv_q[0].len));
        end
        m_axi_arready = ($urandom_range(3) != 0);
      end
    end
  end

  // Stream and status monitor.
  initial begin : monitor
    bt_t e;
    logic [73:0] hv;
    bit held;
    logic es;
    held = 1'b0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held)
          chk("axis_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, hv);
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_bt.size() == 0) begin
            total++;
            $display("FAIL axis_unexpected: got %0h expected none", m_axis_tdata);
          end else begin
            e = exp_bt.pop_front();
            chk("axis_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, e);
          end
        end
        if (sts_done) begin
          if (exp_st.size() == 0) begin
            total++;
            $display("FAIL sts_unexpected: got done expected none");
          end else begin
            es = exp_st.pop_front();
            chk("sts_err", sts_err, es);
          end
        end
        held = m_axis_tvalid && !m_axis_tready;
        hv   = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      end
      @(posedge clk); #1;
      case (tmode)
        0: m_axis_tready = ($urandom_range(3) != 0);
        1: m_axis_tready = 1'b0;
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  task automatic check_reset_outputs();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_araddr", m_axi_araddr, 32'h0);
    chk("rst_arlen", m_axi_arlen, 8'h0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tkeep_tlast", {m_axis_tkeep, m_axis_tlast}, 9'h0);
    chk("rst_sts", {sts_done, sts_err}, 2'b00);
  endtask

  task automatic credit_hold(logic [31:0] a);
    int base;
    tmode = 1;
    base  = ar_cnt;
    issue(a, 1024, -1);
    repeat (200) @(negedge clk);
    chk("credit_ar_count", ar_cnt - base, 4);
    chk("credit_arvalid", m_axi_arvalid, 1'b0);
    chk("credit_rready", m_axi_rready, 1'b1);
    tmode = 0;
    wait_idle(5000);
  endtask

  initial begin : driver
    int len, eb, beats;
    logic [31:0] a;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_rready", m_axi_rready, 1'b1);

    tmode = 2;
    issue(32'h0000_1000, 64, -1);
    wait_idle(2000);
    issue(32'h0000_0FF0, 48, -1);
    wait_idle(2000);
    issue(32'h0000_2000, 13, -1);
    wait_idle(2000);
    issue(32'h0000_3000, 64, 2);
    issue(32'h0000_3000, 64, -1);
    wait_idle(2000);

    credit_hold(32'h0000_4000);

    tmode = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 0)
        a = {12'h0, 4'($urandom_range(15)), 12'h000} + 32'($urandom_range(511) * 8);
      else
        a = {12'h0, 4'($urandom_range(15)), 12'h000} + 32'(4096 - 8 * $urandom_range(1, 20));
      len   = int'($urandom_range(1, 600));
      beats = (len + 7) / 8;
      eb    = ($urandom_range(3) == 0) ? int'($urandom_range(0, beats - 1)) : -1;
      issue(a, len, eb);
    end
    wait_idle(40000);

    issue(32'h0000_5000, 1024, -1);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_ar.delete();
    exp_bt.delete();
    exp_st.delete();
    err_map.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);

    credit_hold(32'h0000_6000);
    tmode = 2;
    issue(32'h0000_7FF8, 21, 1);
    wait_idle(2000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mm2s_burst_engine.md
# mm2s_burst_engine

Parametrised next-generation memory-to-stream DMA read engine. It accepts byte-length transfer commands and splits each into AXI4 INCR read bursts that never cross a 4 KB boundary or exceed MAX_BURST beats. Read data is buffered in an internal FIFO with credit-based burst admission, so R is never back-pressured. The FIFO output is presented as AXI-Stream with a partial tkeep on the final beat and tlast per command. The block sits between the packet-buffer memory interconnect and the capture/replay stream path.

## Interface
- DATA_W, 64, data width in bits for both AXI-MM and AXI-S; one of 32/64/128
- ADDR_W, 32, byte address width
- LEN_W, 16, command byte-length width
- MAX_BURST, 16, maximum beats per burst; power of two, 1..256
- FIFO_DEPTH, 64, data FIFO entries; power of two, at least MAX_BURST
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_W  start byte address; must be DATA_W/8 aligned
- cmd_len  in  LEN_W  transfer length in bytes; 0 is illegal
- sts_done  out  1  one-cycle pulse when a command completes
- sts_err  out  1  valid with sts_done; any non-OKAY rresp during the command
- m_axi_araddr  out  ADDR_W  burst start address
- m_axi_arlen  out  8  beats-1
- m_axi_arsize  out  3  constant log2(DATA_W/8)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid / m_axi_arready  out/in  1  AR handshake
- m_axi_rdata  in  DATA_W  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst; not used for counting
- m_axi_rvalid / m_axi_rready  in/out  1  R handshake
- m_axis_tdata  out  DATA_W  stream data
- m_axis_tkeep  out  DATA_W/8  byte enables
- m_axis_tlast  out  1  final beat of command
- m_axis_tvalid / m_axis_tready  out/in  1  stream handshake

## Operation
- BYTES = DATA_W/8. Total beats = ceil(cmd_len/BYTES).
- AR FSM states:
  - IDLE: cmd_ready=1; on accept, latch the address and load beats_left, then go to CALC.
  - CALC: burst = min(MAX_BURST, beats_left, (4096 - addr[11:0])/BYTES); go to ADDR.
  - ADDR: arvalid is held until arready, with stable payload. On handshake: addr += burst*BYTES, beats_left -= burst. Go to CALC if beats_left != 0, else to DRAIN.
  - DRAIN: wait for the AXIS handshake of tlast, then go to IDLE.
- Credit counter, reset to FIFO_DEPTH:
  - In CALC/ADDR, arvalid is asserted only when credits >= burst.
  - On AR handshake: credits -= burst. On AXIS handshake: credits += 1. Both apply in the same cycle.
- m_axi_rready = 1 whenever not in reset. Credits guarantee FIFO space.
- R side:
  - Each R beat is written to the FIFO with {data, keep, last}.
  - A beat counter marks the last beat of the command. That beat gets last=1 and keep = low (cmd_len mod BYTES) bits set, or all ones if the remainder is 0. All other beats get keep all ones.
- Error flag: set on any R beat with rresp != 2'b00. It is cleared on command accept and reported as sts_err with sts_done.
- The FIFO output drives AXIS directly; tvalid = FIFO not empty.
- Reset mid-operation clears the FSM, FIFO, credits and flags. Draining in-flight AXI reads is a system-level responsibility: the interconnect is reset together with this block.

## Timing
- Reset values: cmd_ready=0 during rst and 1 the cycle after; arvalid=0, araddr=0, arlen=0, rready=0, tvalid=0, tkeep=0, tlast=0, sts_done=0, sts_err=0.
- Command accept to first arvalid: 2 cycles (accept edge, then CALC). Between bursts: 1 CALC cycle.
- R write to tvalid: 1 cycle (registered FIFO, no fall-through). Sustained throughput is 1 beat/cycle when credits allow.
- sts_done pulses the cycle after the tlast handshake. cmd_ready rises in that same cycle; a back-to-back command may be accepted then.
- AXIS stalls (tready=0) hold tdata/tkeep/tlast stable. R is never stalled.

## Structure
- Package mm2s_pkg holds:
  - the AR FSM state enum (IDLE, CALC, ADDR, DRAIN);
  - the AXI constants (BURST_INCR, RESP_OKAY);
  - the 4 KB boundary constant;
  - a function computing BYTES and log2(BYTES).
- Sub-module mm2s_data_fifo: synchronous FIFO, width DATA_W+BYTES+1, depth FIFO_DEPTH, with full/empty and a registered read.

## Test plan
- DATA_W=64, addr 0x1000, len 64: one burst, arlen=7; 8 beats all with keep 0xFF; tlast on beat 8; sts_done=1 with sts_err=0.
- addr 0x0FF0, len 48: split at 4 KB into bursts addr 0x0FF0 arlen=1, then addr 0x1000 arlen=3; 6 stream beats total.
- len 13: 2 beats; second beat keep 0x1F with tlast=1.
- len 512, MAX_BURST=16, FIFO_DEPTH=64, tready=0: at most 4 ARs issued (64 credits) and no further arvalid; rready stays 1. After tready=1, all 64 beats arrive in order.
- rresp=2'b10 on beat 3 of 8: all 8 beats still streamed; sts_err=1 with sts_done. The next command reports sts_err=0.
- rst asserted mid-burst: the next cycle shows all outputs at reset values and credits restored to 64. A new command afterwards completes normally.
